ysyx_23060236_store_buffer: RTL and testbench

//  Posted-write FIFO between LSU write channel (AW/W/B) and xbar write port; LSU sees
//  a one-cycle B response while entries drain to AXI in order. Gates LSU reads on RAW

---
 rtl/ysyx_23060236_store_buffer.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_23060236_store_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_store_buffer.sv
// ysyx_23060236_store_buffer
//
// Posted-write FIFO between the LSU write channel (AW/W/B) and the xbar write
// port. The LSU gets its B acknowledge one cycle after a store is accepted,
// while buffered entries drain to AXI strictly in order, one write
// outstanding at a time (ID 0). Loads are gated while they could alias a
// buffered store (read-after-write). sb_empty tells the EXU that every store
// has been acknowledged by memory, so fence.i can proceed.
//
// Build option:
//   SBUF_RAW_CHECK_EN  defined   : a load is stalled only if its word address
//                                  matches a valid buffered entry.
//                      undefined : a load is stalled until the buffer is empty.
//
// Ports:
//   clock, reset                 core clock; asynchronous active-low reset
//   s_aw*/s_w*/s_b*              LSU-side write channel (slave)
//   s_araddr/s_arvalid/s_arready LSU load request, used for the hazard check
//   m_arvalid/m_arready          load request forwarded to the xbar
//   m_aw*/m_w*/m_b*              xbar-side write channel (master), head entry
//   sb_empty                     no buffered entries and drain FSM idle
//   wr_err                       sticky: some write response was not OKAY
module ysyx_23060236_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awsize,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awsize,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  output logic        m_wlast,
  input  logic        m_wready,
  input  logic        m_bvalid,
  input  logic [1:0]  m_bresp,
  output logic        m_bready,
  output logic        sb_empty,
  output logic        wr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR_DATA,
    S_RESP
  } state_t;

  state_t state, state_next;

  // Entry storage carries no reset; only pointers/count say what is valid.
  logic [31:0] addr_q [DEPTH];
  logic [2:0]  size_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  strb_q [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             bvalid_q;
  logic             err_q;
  logic             aw_done, w_done;

  logic enq, pop, aw_fire, w_fire, hazard;

  assign s_awready = (count != (PTR_W+1)'(DEPTH)) & ~bvalid_q;
  assign s_wready  = s_awready;
  assign enq       = s_awvalid & s_wvalid & s_awready;
  assign pop       = (state == S_RESP) & m_bvalid;

  assign s_bvalid  = bvalid_q;
  assign s_bresp   = 2'b00;
  assign wr_err    = err_q;

  assign m_awaddr  = addr_q[head];
  assign m_awsize  = size_q[head];
  assign m_wdata   = data_q[head];
  assign m_wstrb   = strb_q[head];

  // AW and W rise together and each drops on its own handshake.
  assign m_awvalid = (state == S_ADDR_DATA) & ~aw_done;
  assign m_wvalid  = (state == S_ADDR_DATA) & ~w_done;
  assign m_wlast   = m_wvalid;
  assign m_bready  = (state == S_RESP);
  assign aw_fire   = m_awvalid & m_awready;
  assign w_fire    = m_wvalid & m_wready;

  assign sb_empty  = (count == '0) & (state == S_IDLE);

`ifdef SBUF_RAW_CHECK_EN
  logic [DEPTH-1:0] entry_hit;

  // An entry is live if its distance from head is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    logic [PTR_W-1:0] off;
    assign off          = PTR_W'(g) - head;
    assign entry_hit[g] = ({1'b0, off} < count) &
                          (addr_q[g][31:2] == s_araddr[31:2]);
  end

  assign hazard = |entry_hit;
`else
  logic unused_araddr;

  assign unused_araddr = ^s_araddr;
  assign hazard        = ~sb_empty;
`endif

  assign s_arready = m_arready & ~hazard;
  assign m_arvalid = s_arvalid & ~hazard;

  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail] <= s_awaddr;
      size_q[tail] <= s_awsize;
      data_q[tail] <= s_wdata;
      strb_q[tail] <= s_wstrb;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      bvalid_q <= 1'b0;
      err_q    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      // The entry stays counted until its B arrives.
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // No new accept while the ack is pending, so enq and s_bready never race.
      if (enq)           bvalid_q <= 1'b1;
      else if (s_bready) bvalid_q <= 1'b0;
      if (pop && (m_bresp != 2'b00)) err_q <= 1'b1;
      if (state_next != S_ADDR_DATA) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (count != '0) state_next = S_ADDR_DATA;
      S_ADDR_DATA: if ((aw_done | aw_fire) && (w_done | w_fire)) state_next = S_RESP;
      S_RESP:      if (m_bvalid) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060236_store_buffer.sv
module tb_ysyx_23060236_store_buffer;

  logic        clock;
  logic        reset;
  logic [31:0] s_awaddr;
  logic [2:0]  s_awsize;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awsize;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wlast;
  logic        m_wready;
  logic        m_bvalid;
  logic [1:0]  m_bresp;
  logic        m_bready;
  logic        sb_empty;
  logic        wr_err;

  ysyx_23060236_store_buffer dut (
    .clock(clock), .reset(reset),
    .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_awaddr(m_awaddr), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .sb_empty(sb_empty), .wr_err(wr_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  logic [70:0] exp_q [$];
  logic [34:0] obs_aw [$];
  logic [35:0] obs_w [$];
  int   n_bpop = 0;
  int   n_acc  = 0;
  int   n_awv  = 0;
  bit   last_acc;
  bit   auto_b;
  logic [1:0] auto_bresp;

  // One clock cycle: drive slave B, sample handshakes just before the edge,
  // then return 1 time unit after the rising edge.
  task automatic tick();
    m_bvalid = auto_b & m_bready;
    m_bresp  = auto_bresp;
    #1;
    last_acc = s_awvalid && s_wvalid && s_awready;
    if (last_acc) n_acc++;
    if (m_awvalid) n_awv++;
    if (m_awvalid && m_awready) obs_aw.push_back({m_awaddr, m_awsize});
    if (m_wvalid && m_wready) begin
      obs_w.push_back({m_wdata, m_wstrb});
      if (m_wlast !== 1'b1) begin
        bad++;
        $display("FAIL wlast: got %b want 1", m_wlast);
      end
      total++;
    end
    if (m_bvalid && m_bready) n_bpop++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic [3:0] st);
    bit ok;
    ok = 0;
    s_awaddr = a; s_awsize = sz; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (last_acc) begin ok = 1; break; end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL store_accept_timeout: addr %h not accepted", a);
    end else begin
      exp_q.push_back({a, sz, d, st});
    end
    total++;
    if (s_bvalid !== 1'b1) begin
      bad++;
      $display("FAIL bvalid_latency: got %b want 1", s_bvalid);
    end
    tick();
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300; i++) begin
      if (sb_empty === 1'b1) break;
      tick();
    end
    total++;
    if (sb_empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_timeout: sb_empty got %b want 1", sb_empty);
    end
  endtask

  task automatic check_drained();
    logic [70:0] e;
    logic [34:0] oa;
    logic [35:0] ow;
    total++;
    if (obs_aw.size() !== exp_q.size() || obs_w.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL drain_count: aw %0d w %0d want %0d", obs_aw.size(), obs_w.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_aw.size() > 0 && obs_w.size() > 0) begin
      e = exp_q.pop_front(); oa = obs_aw.pop_front(); ow = obs_w.pop_front();
      total++;
      if (oa !== e[70:36]) begin
        bad++;
        $display("FAIL drain_aw: got %h want %h", oa, e[70:36]);
      end
      total++;
      if (ow !== e[35:0]) begin
        bad++;
        $display("FAIL drain_w: got %h want %h", ow, e[35:0]);
      end
    end
    exp_q.delete(); obs_aw.delete(); obs_w.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid: got %b want 0", s_bvalid); end
    total++; if (m_awvalid !== 1'b0) begin bad++; $display("FAIL rst_awvalid: got %b want 0", m_awvalid); end
    total++; if (m_wvalid !== 1'b0) begin bad++; $display("FAIL rst_wvalid: got %b want 0", m_wvalid); end
    total++; if (m_bready !== 1'b0) begin bad++; $display("FAIL rst_bready: got %b want 0", m_bready); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL rst_wr_err: got %b want 0", wr_err); end
    total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rst_sb_empty: got %b want 1", sb_empty); end
    total++; if (s_awready !== 1'b1) begin bad++; $display("FAIL rst_awready: got %b want 1", s_awready); end
    total++; if (s_bresp !== 2'b00) begin bad++; $display("FAIL rst_bresp: got %b want 00", s_bresp); end
  endtask

  task automatic test_single_store();
    do_store(32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 4'hF);
    wait_empty();
    check_drained();
    total++;
    if (n_bpop !== 1) begin bad++; $display("FAIL single_bpop: got %0d want 1", n_bpop); end
  endtask

  task automatic test_back_to_back();
    int acc0, bpop0;
    bit ok;
    m_awready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_store(32'h8000_1000 + 32'(i) * 4, 3'd2, 32'h1111_0000 + 32'(i), 4'(i + 1));
    total++;
    if (s_awready !== 1'b0) begin bad++; $display("FAIL full_awready: got %b want 0", s_awready); end
    acc0 = n_acc;
    s_awaddr = 32'h8000_1010; s_awsize = 3'd0; s_wdata = 32'h5555_AAAA; s_wstrb = 4'h1;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    repeat (3) tick();
    total++;
    if (n_acc !== acc0) begin bad++; $display("FAIL full_block: accepts got %0d want %0d", n_acc, acc0); end
    bpop0 = n_bpop;
    m_awready = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_acc) begin ok = 1; break; end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL fifth_accept: got %b want 1", ok); end
    else exp_q.push_back({32'h8000_1010, 3'd0, 32'h5555_AAAA, 4'h1});
    total++;
    if ((n_bpop > bpop0) !== 1'b1) begin bad++; $display("FAIL fifth_before_pop: pops %0d want >%0d", n_bpop, bpop0); end
    tick();
    wait_empty();
    check_drained();
  endtask

  task automatic test_skew();
    m_awready = 1'b1; m_wready = 1'b0;
    do_store(32'h8000_0040, 3'd1, 32'h0000_BEEF, 4'h3);
    total++;
    if ({m_awvalid, m_wvalid} !== 2'b11) begin bad++; $display("FAIL skew_rise: got %b want 11", {m_awvalid, m_wvalid}); end
    tick();
    total++;
    if ({m_awvalid, m_wvalid, m_bready} !== 3'b010) begin bad++; $display("FAIL skew_aw_drop: got %b want 010", {m_awvalid, m_wvalid, m_bready}); end
    tick(); tick();
    total++;
    if ({m_awvalid, m_wvalid, m_bready} !== 3'b010) begin bad++; $display("FAIL skew_w_held: got %b want 010", {m_awvalid, m_wvalid, m_bready}); end
    m_wready = 1'b1;
    tick();
    total++;
    if ({m_awvalid, m_wvalid, m_bready} !== 3'b001) begin bad++; $display("FAIL skew_resp: got %b want 001", {m_awvalid, m_wvalid, m_bready}); end
    wait_empty();
    check_drained();
  endtask

  task automatic test_hazard();
    logic exp_pass;
    m_awready = 1'b0;
    do_store(32'h8000_0100, 3'd2, 32'hCAFE_0100, 4'hF);
    s_araddr = 32'h8000_0102; s_arvalid = 1'b1;
    #1;
    total++;
    if ({m_arvalid, s_arready} !== 2'b00) begin bad++; $display("FAIL raw_block: got %b want 00", {m_arvalid, s_arready}); end
    s_araddr = 32'h8000_0200;
    #1;
`ifdef SBUF_RAW_CHECK_EN
    exp_pass = 1'b1;
`else
    exp_pass = 1'b0;
`endif
    total++;
    if (m_arvalid !== exp_pass) begin bad++; $display("FAIL raw_other: got %b want %b", m_arvalid, exp_pass); end
    s_araddr = 32'h8000_0102;
    m_awready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_arvalid === 1'b1) break;
      tick();
    end
    total++;
    if ({m_arvalid, s_arready, sb_empty} !== 3'b111) begin bad++; $display("FAIL raw_release: got %b want 111", {m_arvalid, s_arready, sb_empty}); end
    s_arvalid = 1'b0;
    check_drained();
  endtask

  task automatic test_bresp_err();
    auto_bresp = 2'b10;
    do_store(32'h8000_0300, 3'd2, 32'h0BAD_0BAD, 4'hF);
    wait_empty();
    total++;
    if (wr_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", wr_err); end
    check_drained();
    auto_bresp = 2'b00;
    do_store(32'h8000_0304, 3'd2, 32'h600D_600D, 4'hF);
    wait_empty();
    total++;
    if (wr_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", wr_err); end
    check_drained();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ({wr_err, sb_empty} !== 2'b01) begin bad++; $display("FAIL err_clear: got %b want 01", {wr_err, sb_empty}); end
  endtask

  task automatic test_reset_mid_resp();
    int awv0;
    auto_b = 1'b0;
    for (int i = 0; i < 3; i++)
      do_store(32'h8000_0400 + 32'(i) * 4, 3'd2, 32'hA5A5_0000 + 32'(i), 4'hF);
    for (int i = 0; i < 50; i++) begin
      if (m_bready === 1'b1) break;
      tick();
    end
    total++;
    if (m_bready !== 1'b1) begin bad++; $display("FAIL mid_resp_reach: got %b want 1", m_bready); end
    reset = 1'b0;
    #1;
    total++;
    if ({s_bvalid, m_awvalid, m_wvalid, m_bready, wr_err, sb_empty, s_awready} !== 7'b0000011) begin
      bad++;
      $display("FAIL mid_resp_reset: got %b want 0000011",
               {s_bvalid, m_awvalid, m_wvalid, m_bready, wr_err, sb_empty, s_awready});
    end
    tick();
    reset = 1'b1;
    auto_b = 1'b1;
    exp_q.delete(); obs_aw.delete(); obs_w.delete();
    awv0 = n_awv;
    repeat (10) tick();
    total++;
    if (n_awv !== awv0) begin bad++; $display("FAIL no_replay: awvalid cycles got %0d want %0d", n_awv - awv0, 0); end
    total++;
    if (sb_empty !== 1'b1) begin bad++; $display("FAIL post_reset_empty: got %b want 1", sb_empty); end
  endtask

  initial begin
    reset = 1'b0;
    s_awaddr = '0; s_awsize = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b1;
    s_araddr = '0; s_arvalid = 1'b0;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    auto_b = 1'b1; auto_bresp = 2'b00;
    @(posedge clock);
    #1;
    test_reset();
    test_single_store();
    test_back_to_back();
    test_skew();
    test_hazard();
    test_bresp_err();
    test_reset_mid_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
